// File: rtl/button_press_classifier.sv
// Classifies debounced button activity into short, long and double press pulses
// and maintains a 4-digit BCD count of button presses for the display driver.
module button_press_classifier #(
    parameter int unsigned      CNT_W        = 24,
    parameter logic [CNT_W-1:0] LONG_TICKS   = 24'd12_000_000,
    parameter logic [CNT_W-1:0] DOUBLE_TICKS = 24'd6_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic        clear,
    output logic        short_press,
    output logic        long_press,
    output logic        double_press,
    output logic        held,
    output logic [15:0] press_count
);

    localparam logic [CNT_W-1:0] LONG_LAST   = LONG_TICKS - CNT_W'(1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = DOUBLE_TICKS - CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG_HELD,
        WAIT2,
        PRESS2
    } state_t;

    state_t           state;
    logic             btn_q;
    logic [CNT_W-1:0] timer;
    logic             rise;
    logic             fall;

    assign rise = btn & ~btn_q;
    assign fall = ~btn & btn_q;

    // Increment a 4-digit BCD value; 9999 rolls over to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (result[i*4 +: 4] == 4'd9) begin
                    result[i*4 +: 4] = 4'd0;
                end else begin
                    result[i*4 +: 4] = result[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            btn_q        <= 1'b0;
            timer        <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            held         <= 1'b0;
            press_count  <= '0;
        end else begin
            btn_q        <= btn;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;

            // Clear beats a coincident rise; the rise is still classified below.
            if (clear) begin
                press_count <= '0;
            end else if (rise) begin
                press_count <= bcd_inc(press_count);
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= PRESS1;
                        timer <= '0;
                    end
                end
                PRESS1: begin
                    timer <= timer + 1'b1;
                    if (fall) begin
                        state <= WAIT2;
                        timer <= '0;
                    end else if (btn && timer == LONG_LAST) begin
                        state      <= LONG_HELD;
                        long_press <= 1'b1;
                        held       <= 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end
                end
                WAIT2: begin
                    timer <= timer + 1'b1;
                    if (rise) begin
                        state        <= PRESS2;
                        double_press <= 1'b1;
                    end else if (timer == DOUBLE_LAST) begin
                        state       <= IDLE;
                        short_press <= 1'b1;
                    end
                end
                PRESS2: begin
                    if (fall) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: button waveforms built from high/low segments,
// expected outputs derived from segment lengths and the press-count rules.
module tb_button_press_classifier;

    localparam int LT = 20;
    localparam int DT = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn = 1'b0;
    logic        clear = 1'b0;
    logic        short_press;
    logic        long_press;
    logic        double_press;
    logic        held;
    logic [15:0] press_count;

    int tests = 0;
    int fails = 0;
    string cur_run = "init";
    int cur_cyc = 0;

    bit wave[$];
    bit clr[$];
    bit exp_s[];
    bit exp_l[];
    bit exp_d[];
    bit exp_h[];
    int exp_c[];

    button_press_classifier #(
        .CNT_W(24),
        .LONG_TICKS(24'd20),
        .DOUBLE_TICKS(24'd10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .clear(clear),
        .short_press(short_press),
        .long_press(long_press),
        .double_press(double_press),
        .held(held),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s [%s cycle %0d] got=%0h expected=%0h", tag, cur_run, cur_cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        return 32'((v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    task automatic seg(input bit b, input int len, input bit c = 1'b0);
        for (int i = 0; i < len; i++) begin
            wave.push_back(b);
            clr.push_back(c && i == 0);
        end
    endtask

    function automatic bit is_rise(input int k);
        return wave[k] && (k == 0 || !wave[k-1]);
    endfunction

    // Walk the waveform press by press: each episode starts at a rise in idle.
    function automatic void build_model();
        int n, k, r, h, f, l, h2, cnt;
        n = wave.size();
        exp_s = new[n];
        exp_l = new[n];
        exp_d = new[n];
        exp_h = new[n];
        exp_c = new[n];
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (clr[i]) cnt = 0;
            else if (is_rise(i)) cnt = (cnt + 1) % 10000;
            exp_c[i] = cnt;
        end
        k = 0;
        while (k < n) begin
            r = k;
            while (r < n && !is_rise(r)) r++;
            if (r >= n) break;
            h = 0;
            while (r + h < n && wave[r+h]) h++;
            if (h >= LT + 1) begin
                exp_l[r+LT] = 1'b1;
                for (int i = r + LT; i < r + h; i++) exp_h[i] = 1'b1;
                k = r + h;
                continue;
            end
            f = r + h;
            if (f >= n) break;
            l = 0;
            while (f + l < n && !wave[f+l]) l++;
            if (l > DT) begin
                exp_s[f+DT] = 1'b1;
                k = f + DT + 1;
            end else if (f + l < n) begin
                exp_d[f+l] = 1'b1;
                h2 = 0;
                while (f + l + h2 < n && wave[f+l+h2]) h2++;
                k = f + l + h2;
            end else begin
                break;
            end
        end
    endfunction

    task automatic run_it(input string name);
        int n;
        n = wave.size();
        cur_run = name;
        build_model();
        reset = 1'b1;
        btn = 1'b0;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            reset = 1'b0;
            btn = wave[k];
            clear = clr[k];
            @(posedge clk);
            #1;
            cur_cyc = k;
            check("short", 32'(short_press), 32'(exp_s[k]));
            check("long", 32'(long_press), 32'(exp_l[k]));
            check("double", 32'(double_press), 32'(exp_d[k]));
            check("held", 32'(held), 32'(exp_h[k]));
            check("count", 32'(press_count), to_bcd(exp_c[k]));
        end
        wave.delete();
        clr.delete();
    endtask

    initial begin
        // Reset mid-PRESS1 with the timer at 12, then quiet input.
        seg(1'b1, 13);
        run_it("pre_reset");
        #2 reset = 1'b1;
        #1;
        cur_run = "async_reset";
        check("rst_short", 32'(short_press), 32'd0);
        check("rst_long", 32'(long_press), 32'd0);
        check("rst_double", 32'(double_press), 32'd0);
        check("rst_held", 32'(held), 32'd0);
        check("rst_count", 32'(press_count), 32'd0);
        seg(1'b0, 50);
        run_it("post_reset");

        seg(1'b0, 2); seg(1'b1, 5); seg(1'b0, 30);
        run_it("short");
        seg(1'b0, 2); seg(1'b1, 40); seg(1'b0, 10);
        run_it("long");
        seg(1'b0, 2); seg(1'b1, 20); seg(1'b0, 15);
        run_it("long_edge_release");
        seg(1'b0, 2); seg(1'b1, 21); seg(1'b0, 5);
        run_it("long_edge_hold");
        seg(1'b0, 2); seg(1'b1, 3); seg(1'b0, 4); seg(1'b1, 3); seg(1'b0, 15);
        run_it("double");
        seg(1'b0, 2); seg(1'b1, 3); seg(1'b0, 10); seg(1'b1, 3); seg(1'b0, 15);
        run_it("double_on_limit");
        seg(1'b0, 2); seg(1'b1, 3); seg(1'b0, 11); seg(1'b1, 3); seg(1'b0, 15);
        run_it("double_late");
        seg(1'b1, 5); seg(1'b0, 15);
        run_it("high_at_reset");
        seg(1'b0, 2); seg(1'b1, 2); seg(1'b0, 15); seg(1'b1, 3, 1'b1); seg(1'b0, 15);
        run_it("clear_on_rise");
        for (int i = 0; i < 10000; i++) begin
            seg(1'b1, 1);
            seg(1'b0, 1);
        end
        seg(1'b1, 3); seg(1'b0, 15);
        run_it("count_wrap");

        for (int r = 0; r < 6; r++) begin
            bit lvl;
            lvl = 1'(($urandom() >> 3) & 1);
            while (wave.size() < 300) begin
                seg(lvl, $urandom_range(1, 45));
                lvl = ~lvl;
            end
            seg(1'b0, 15);
            for (int i = 0; i < wave.size(); i++)
                if ($urandom_range(0, 49) == 0) clr[i] = 1'b1;
            run_it($sformatf("random_%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout [%s cycle %0d] got=running expected=finished", cur_run, cur_cyc);
        $fatal(1, "bench time limit reached");
    end

endmodule
